// File: rtl/tgt_ddr_rx_pkg.sv
// rtl/tgt_ddr_rx_pkg.sv - HDR-DDR field encodings and bit counts shared by target rx/tx.
package tgt_ddr_rx_pkg;

    localparam logic [3:0] DDR_CRC_TOKEN_VAL = 4'b1100;
    localparam int         DDR_CRC_W         = 5;

    localparam logic [2:0] MODE_PREAMBLE   = 3'b000;
    localparam logic [2:0] MODE_CRC_TOKEN  = 3'b010;
    localparam logic [2:0] MODE_DESER_BYTE = 3'b011;
    localparam logic [2:0] MODE_PARITY     = 3'b110;
    localparam logic [2:0] MODE_CRC_VALUE  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_DONE
    } rx_state_e;

    // Zero marks an illegal field encoding.
    function automatic logic [3:0] mode_bit_count(input logic [2:0] mode);
        case (mode)
            MODE_PREAMBLE:   mode_bit_count = 4'd2;
            MODE_DESER_BYTE: mode_bit_count = 4'd8;
            MODE_PARITY:     mode_bit_count = 4'd2;
            MODE_CRC_TOKEN:  mode_bit_count = 4'd4;
            MODE_CRC_VALUE:  mode_bit_count = 4'd5;
            default:         mode_bit_count = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ddr_parity_calc.sv
// rtl/ddr_parity_calc.sv - HDR-DDR parity pair {PA1,PA0} over a 16-bit data word.
module ddr_parity_calc (
    input  logic [15:0] i_word,
    output logic [1:0]  o_parity
);

    logic pa1;
    logic pa0;

    // PA1 covers odd bit positions, PA0 covers even positions and is inverted.
    always_comb begin
        pa1 = 1'b0;
        pa0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pa1 = pa1 ^ i_word[2*i+1];
            pa0 = pa0 ^ i_word[2*i];
        end
    end

    assign o_parity = {pa1, pa0};

endmodule

// File: rtl/tgt_ddr_rx.sv
// rtl/tgt_ddr_rx.sv - target HDR-DDR receive deserializer sampling SDA on both SCL edges.
module tgt_ddr_rx
    import tgt_ddr_rx_pkg::*;
#(
    parameter logic [3:0] CRC_TOKEN_VAL = DDR_CRC_TOKEN_VAL,
    parameter int          CRC_W         = DDR_CRC_W
) (
    input  logic             i_sys_clk,
    input  logic             i_sys_rst,
    input  logic             i_sclgen_scl_pos_edge,
    input  logic             i_sclgen_scl_neg_edge,
    input  logic             i_sdahnd_tgt_serial_data,
    input  logic             i_ddrccc_rx_en,
    input  logic [2:0]       i_ddrccc_rx_mode,
    input  logic [CRC_W-1:0] i_crc_crc_value,
    output logic [7:0]       o_regf_rx_parallel_data,
    output logic [1:0]       o_ddrccc_rx_preamble,
    output logic             o_ddrccc_rx_mode_done,
    output logic             o_ddrccc_error,
    output logic             o_crc_en,
    output logic [7:0]       o_crc_parallel_data
);

    rx_state_e   state_q, state_d;
    logic [2:0]  mode_q, mode_d;
    logic [2:0]  count_q, count_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] word_q, word_d;
    logic        byte_idx_q, byte_idx_d;
    logic        illegal_q, illegal_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic [1:0]  preamble_q, preamble_d;
    logic [7:0]  crc_data_q, crc_data_d;

    logic [7:0]  shift_nxt;
    logic [3:0]  field_len;
    logic        scl_edge;
    logic [1:0]  parity;
    logic        field_err;

    ddr_parity_calc u_parity (
        .i_word   (word_q),
        .o_parity (parity)
    );

    // Coincident edges are a protocol error; they still shift only one bit.
    assign scl_edge  = i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge;
    assign shift_nxt = {shift_q[6:0], i_sdahnd_tgt_serial_data};
    assign field_len = mode_bit_count(i_ddrccc_rx_mode);

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        count_d    = count_q;
        shift_d    = shift_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        illegal_d  = illegal_q;
        rx_data_d  = rx_data_q;
        preamble_d = preamble_q;
        crc_data_d = crc_data_q;

        case (state_q)
            ST_IDLE: begin
                if (i_ddrccc_rx_en) begin
                    mode_d  = i_ddrccc_rx_mode;
                    shift_d = 8'h00;
                    if (field_len == 4'd0) begin
                        illegal_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        illegal_d = 1'b0;
                        count_d   = 3'(field_len - 4'd1);
                        state_d   = ST_RECV;
                    end
                end
            end
            ST_RECV: begin
                if (!i_ddrccc_rx_en) begin
                    state_d = ST_IDLE;
                end else if (scl_edge) begin
                    shift_d = shift_nxt;
                    count_d = count_q - 3'd1;
                    if (count_q == 3'd0) begin
                        state_d = ST_DONE;
                        case (mode_q)
                            MODE_PREAMBLE: begin
                                preamble_d = shift_nxt[1:0];
                                byte_idx_d = 1'b0;
                            end
                            MODE_DESER_BYTE: begin
                                rx_data_d  = shift_nxt;
                                crc_data_d = shift_nxt;
                                if (byte_idx_q) begin
                                    word_d[7:0] = shift_nxt;
                                end else begin
                                    word_d[15:8] = shift_nxt;
                                end
                                byte_idx_d = ~byte_idx_q;
                            end
                            MODE_PARITY: byte_idx_d = 1'b0;
                            default: ;
                        endcase
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= 3'b000;
            count_q    <= 3'd0;
            shift_q    <= 8'h00;
            word_q     <= 16'h0000;
            byte_idx_q <= 1'b0;
            illegal_q  <= 1'b0;
            rx_data_q  <= 8'h00;
            preamble_q <= 2'b00;
            crc_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            illegal_q  <= illegal_d;
            rx_data_q  <= rx_data_d;
            preamble_q <= preamble_d;
            crc_data_q <= crc_data_d;
        end
    end

    // The CRC value is compared against the engine's output as it stands in DONE.
    always_comb begin
        field_err = 1'b0;
        case (mode_q)
            MODE_PARITY:    field_err = (shift_q[1:0] != parity);
            MODE_CRC_TOKEN: field_err = (shift_q[3:0] != CRC_TOKEN_VAL);
            MODE_CRC_VALUE: field_err = (shift_q[CRC_W-1:0] != i_crc_crc_value);
            default:        field_err = 1'b0;
        endcase
    end

    assign o_ddrccc_rx_mode_done   = (state_q == ST_DONE);
    assign o_ddrccc_error          = (state_q == ST_DONE) && (illegal_q || field_err);
    assign o_crc_en                = (state_q == ST_DONE) && !illegal_q && (mode_q == MODE_DESER_BYTE);
    assign o_regf_rx_parallel_data = rx_data_q;
    assign o_ddrccc_rx_preamble    = preamble_q;
    assign o_crc_parallel_data     = crc_data_q;

endmodule

// File: tb/tb_tgt_ddr_rx.sv
// tb/tb_tgt_ddr_rx.sv - randomized self-checking bench for tgt_ddr_rx against a field-level model.
module tb_tgt_ddr_rx;

    localparam logic [2:0] M_PRE  = 3'b000;
    localparam logic [2:0] M_TOK  = 3'b010;
    localparam logic [2:0] M_BYTE = 3'b011;
    localparam logic [2:0] M_PAR  = 3'b110;
    localparam logic [2:0] M_CRCV = 3'b111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pos = 1'b0;
    logic       neg = 1'b0;
    logic       sda = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mode = 3'b000;
    logic [4:0] crc_val = 5'h00;
    logic [7:0] rx_data;
    logic [1:0] pre;
    logic       done;
    logic       err;
    logic       crc_en;
    logic [7:0] crc_data;

    int n_vec = 0;
    int n_miss = 0;

    logic [7:0] exp_data = 8'h00;
    logic [7:0] exp_crc_data = 8'h00;
    logic [1:0] exp_pre = 2'b00;
    logic [7:0] wb [2];
    int         widx = 0;

    tgt_ddr_rx dut (
        .i_sys_clk                (clk),
        .i_sys_rst                (rst),
        .i_sclgen_scl_pos_edge    (pos),
        .i_sclgen_scl_neg_edge    (neg),
        .i_sdahnd_tgt_serial_data (sda),
        .i_ddrccc_rx_en           (en),
        .i_ddrccc_rx_mode         (mode),
        .i_crc_crc_value          (crc_val),
        .o_regf_rx_parallel_data  (rx_data),
        .o_ddrccc_rx_preamble     (pre),
        .o_ddrccc_rx_mode_done    (done),
        .o_ddrccc_error           (err),
        .o_crc_en                 (crc_en),
        .o_crc_parallel_data      (crc_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        chk("quiet {done,err,crc_en}", {done, err, crc_en}, 3'b000);
    endtask

    function automatic int field_len(input logic [2:0] m);
        case (m)
            M_PRE, M_PAR: return 2;
            M_TOK:        return 4;
            M_CRCV:       return 5;
            M_BYTE:       return 8;
            default:      return 0;
        endcase
    endfunction

    // Parity rule from the word: PA1 = XOR of odd bits, PA0 = inverted XOR of even bits.
    function automatic logic [1:0] model_parity();
        logic [15:0] w;
        logic p1;
        logic p0;
        w  = {wb[0], wb[1]};
        p1 = 1'b0;
        p0 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 1) p1 = p1 ^ w[i];
            else            p0 = p0 ^ w[i];
        end
        return {p1, p0};
    endfunction

    task automatic model_reset();
        exp_data     = 8'h00;
        exp_crc_data = 8'h00;
        exp_pre      = 2'b00;
        wb[0]        = 8'h00;
        wb[1]        = 8'h00;
        widx         = 0;
    endtask

    // abort_at > 0: stop after that many edges (drop en, or pulse reset if use_rst).
    task automatic run_field(input logic [2:0] m, input logic [7:0] v, input int lead,
                             input int abort_at, input bit use_rst);
        int  n;
        int  sel;
        logic e;
        n    = field_len(m);
        en   = 1'b1;
        mode = m;
        if (n == 0) begin
            tick();
            chk("illegal {done,err,crc_en}", {done, err, crc_en}, 3'b110);
            return;
        end
        for (int k = 0; k < lead; k++) begin
            tick();
            quiet();
        end
        for (int i = 0; i < n; i++) begin
            sda = v[n-1-i];
            sel = $urandom_range(0, 9);
            pos = (sel < 5) || (sel == 9);
            neg = (sel >= 5);
            tick();
            pos = 1'b0;
            neg = 1'b0;
            sda = 1'($urandom);
            if (abort_at == i + 1) begin
                if (use_rst) begin
                    rst = 1'b1;
                    tick();
                    chk("reset outputs", {done, err, crc_en, rx_data, pre, crc_data}, 0);
                    rst = 1'b0;
                    en  = 1'b0;
                    model_reset();
                    tick();
                    quiet();
                end else begin
                    en = 1'b0;
                    repeat (3) begin
                        tick();
                        quiet();
                        chk("abort hold rx_data", rx_data, exp_data);
                        chk("abort hold preamble", pre, exp_pre);
                    end
                end
                return;
            end
            if (i == n - 1) begin
                e = 1'b0;
                case (m)
                    M_PRE: begin
                        exp_pre = v[1:0];
                        widx    = 0;
                    end
                    M_BYTE: begin
                        exp_data     = v;
                        exp_crc_data = v;
                        wb[widx]     = v;
                        widx         = 1 - widx;
                    end
                    M_PAR: begin
                        e    = (v[1:0] != model_parity());
                        widx = 0;
                    end
                    M_TOK:  e = (v[3:0] != 4'b1100);
                    M_CRCV: e = (v[4:0] != crc_val);
                    default: ;
                endcase
                chk("done", done, 1);
                chk("error", err, e);
                chk("crc_en", crc_en, (m == M_BYTE));
                chk("rx_data", rx_data, exp_data);
                chk("preamble", pre, exp_pre);
                chk("crc_data", crc_data, exp_crc_data);
            end else begin
                quiet();
                repeat ($urandom_range(2, 4)) begin
                    tick();
                    quiet();
                end
            end
        end
    endtask

    task automatic go_idle();
        en = 1'b0;
        tick();
        quiet();
    endtask

    initial begin
        logic [2:0] modes [8];
        logic [2:0] m;
        logic [7:0] v;
        int         ab;
        modes = '{M_PRE, 3'b001, M_TOK, M_BYTE, 3'b100, 3'b101, M_PAR, M_CRCV};
        model_reset();

        repeat (3) tick();
        chk("reset state", {done, err, crc_en, rx_data, pre, crc_data}, 0);
        rst = 1'b0;
        tick();
        quiet();

        run_field(M_PRE, 8'b10, 1, 0, 0);

        run_field(M_BYTE, 8'h85, 2, 0, 0);
        run_field(M_BYTE, 8'h2B, 2, 0, 0);
        run_field(M_PAR, {6'b0, model_parity()}, 2, 0, 0);
        run_field(M_PAR, {6'b0, model_parity() ^ 2'b01}, 2, 0, 0);

        run_field(M_TOK, 8'h0C, 2, 0, 0);
        run_field(M_TOK, 8'h0A, 2, 0, 0);

        crc_val = 5'h13;
        run_field(M_CRCV, 8'h13, 2, 0, 0);
        crc_val = 5'h07;
        run_field(M_CRCV, 8'h13, 2, 0, 0);

        run_field(M_BYTE, 8'hC6, 2, 3, 0);
        run_field(M_PRE, 8'b01, 1, 0, 0);
        run_field(M_BYTE, 8'h5A, 2, 3, 1);
        run_field(M_PRE, 8'b11, 1, 0, 0);

        go_idle();
        run_field(3'b100, 8'h00, 0, 0, 0);
        run_field(M_PRE, 8'b10, 2, 0, 0);

        for (int it = 0; it < 60; it++) begin
            go_idle();
            m       = modes[$urandom_range(0, 7)];
            v       = 8'($urandom);
            crc_val = ($urandom_range(0, 1) == 1) ? v[4:0] : 5'($urandom);
            if (m == M_PAR && $urandom_range(0, 1) == 1) v[1:0] = model_parity();
            ab = 0;
            if (field_len(m) > 1 && $urandom_range(0, 7) == 0)
                ab = $urandom_range(1, field_len(m) - 1);
            run_field(m, v, $urandom_range(1, 3), ab, ($urandom_range(0, 3) == 0));
        end

        go_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
